reg_change_fifo: RTL and testbench
==================================

Name: reg_change_fifo

Overview:
- Sits directly downstream of the clocked output register on the register bus.
- Samples the register's data_out every clock and detects value changes.
- Each change is pushed as a {timestamp, data} entry into a small show-ahead FIFO.
- Testbench monitors and debug logic pop entries with a read-enable handshake. Overflow is flagged, never silent.

Parameters:
- DATA_W, 8: width of the sampled register data.
- TS_W, 16: width of the free-running timestamp counter.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  register data_out being monitored.
- rd_en  input  1  pop request; honoured only when empty=0.
- clr_ovf  input  1  clears the sticky overflow flag.
- rd_data  output  DATA_W  data of head entry; 0 when empty.
- rd_ts  output  TS_W  timestamp of head entry; 0 when empty.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky: a change was dropped while full.

Behaviour:
- Reset (rst=1 at posedge) clears the following:
  - ts_q=0, prev_q=0, prev_valid=0;
  - read/write pointers=0, count=0, overflow=0.
  - Outputs: empty=1, full=0, rd_data=0, rd_ts=0.
  - Applies mid-operation too: all stored entries are discarded.
- Timestamp: ts_q increments by 1 on every non-reset posedge, modulo 2^TS_W. It wraps silently from all-ones to 0.
- Baseline: prev_q<=data_in on every non-reset posedge, and prev_valid<=1.
  - The first post-reset edge only captures the baseline; nothing is pushed.
- Change detect (combinational): chg = prev_valid && (data_in != prev_q).
- Push: at a posedge with chg=1 and a free slot, write {ts_q (pre-increment value), data_in} at the write pointer.
  - Latency: entry is visible at rd_data/rd_ts, with empty=0, immediately after that edge.
- Free slot means count<DEPTH, or count==DEPTH with rd_en=1 in the same cycle.
- Pop: at a posedge with rd_en=1 and empty=0, advance the read pointer.
  - rd_en while empty is ignored: no pointer or count change, no error flag.
- Simultaneous push and pop:
  - Non-empty: both occur, count unchanged.
  - Full: both occur, count stays DEPTH, overflow not set.
  - Empty: push occurs, pop ignored, count becomes 1.
- Overflow: chg=1 while count==DEPTH and rd_en=0 drops the change and sets overflow<=1.
  - Stored entries are untouched.
  - prev_q still updates, so a value that returns to the dropped value produces a new change.
- clr_ovf=1 clears overflow at the next edge. If a new overflow event happens in the same cycle, set wins.
- Show-ahead output: rd_data/rd_ts = head entry when empty=0, forced to 0 when empty=1.
- Flags: empty=(count==0), full=(count==DEPTH). count, empty and full are registered and consistent in every cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- No combinational path from rd_en to empty, full or count.

Test Plan:
- Reset behaviour: hold rst=1 for 2 cycles with data_in=8'h5A.
  -> empty=1, full=0, count=0, overflow=0, rd_data=0, rd_ts=0.
  - First edge after release pushes nothing even though data_in≠0 (baseline).
- Single change: release rst; data_in=8'h00 at the baseline edge (ts_q=0); data_in=8'hA5 before the edge where ts_q=3, then held.
  -> exactly one entry: rd_data=8'hA5, rd_ts=3, count=1, empty=0.
  - No further pushes while data_in is held.
- Fill and overflow (DEPTH=4, no reads): apply 5 distinct changes 8'h01..8'h05 on consecutive edges.
  -> count=4, full=1, overflow=1.
  - Pops return 01, 02, 03, 04 with consecutive timestamps; 05 is absent.
- Push and pop at full: count=4, then chg=1 with rd_en=1 in the same cycle.
  -> count stays 4, overflow stays 0.
  - Head advances by one; the new entry is last.
- Empty handling: rd_en=1 while empty.
  -> count stays 0, no flags change.
  - clr_ovf=1 with overflow=1 and no overflow event -> overflow=0 next cycle.
  - clr_ovf=1 coincident with an overflow event -> overflow stays 1.
- Reset mid-operation: count=3, then assert rst for 1 cycle.
  -> count=0, empty=1, ts_q=0.
  - The change present at the first post-reset edge is not pushed; the next change is pushed with rd_ts=1.

Source files
------------

// File: rtl/reg_change_fifo.sv
// Change monitor for a clocked register output: every new data_in value is
// pushed with a free-running timestamp into a small show-ahead FIFO.
module reg_change_fifo #(
  parameter int DATA_W = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              empty_q;
  logic              full_q;
  logic              overflow_q;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];

  logic chg;
  logic pop;
  logic push;
  logic ovf_evt;

  // A full FIFO still accepts a change when the head is popped in the same cycle.
  always_comb begin
    chg       = prev_valid && (data_in != prev_q);
    pop       = rd_en && !empty_q;
    push      = chg && (!full_q || rd_en);
    ovf_evt   = chg && full_q && !rd_en;
    count_nxt = count_q;
    unique case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      prev_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_q + TS_W'(1);
      prev_q     <= data_in;
      prev_valid <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q    <= count_nxt;
      empty_q    <= (count_nxt == '0);
      full_q     <= (count_nxt == CNT_W'(DEPTH));
      if (ovf_evt)      overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the read port is gated by empty and pointers restart at zero.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_data[wr_ptr] <= data_in;
      mem_ts[wr_ptr]   <= ts_q;
    end
  end

  assign rd_data  = empty_q ? '0 : mem_data[rd_ptr];
  assign rd_ts    = empty_q ? '0 : mem_ts[rd_ptr];
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reg_change_fifo.sv
// Bench for reg_change_fifo: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_reg_change_fifo;

  localparam int DATA_W = 8;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_ts;
  logic              empty;
  logic              full;
  logic [2:0]        count;
  logic              overflow;

  int n_cmp = 0;
  int n_bad = 0;

  reg_change_fifo #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_ts    (rd_ts),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of {timestamp, data} plus scalar state.
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mq[$];
  logic [TS_W-1:0]   m_ts;
  logic [DATA_W-1:0] m_prev;
  bit                m_pv;
  bit                m_ovf;

  task automatic model_edge();
    bit changed;
    bit dropped;
    if (rst) begin
      mq.delete();
      m_ts   = '0;
      m_prev = '0;
      m_pv   = 0;
      m_ovf  = 0;
    end else begin
      changed = m_pv && (data_in != m_prev);
      dropped = 0;
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      if (changed) begin
        if (mq.size() < DEPTH) mq.push_back('{ts: m_ts, data: data_in});
        else dropped = 1;
      end
      if (dropped)      m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_ts   = m_ts + 1'b1;
      m_prev = data_in;
      m_pv   = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply(input logic r, input logic [7:0] d, input logic rd, input logic clr);
    rst = r; data_in = d; rd_en = rd; clr_ovf = clr;
    tick();
  endtask

  task automatic compare_model(input string tag);
    int n;
    n = mq.size();
    check({tag, " count"},    32'(count),    32'(n));
    check({tag, " empty"},    32'(empty),    32'(n == 0));
    check({tag, " full"},     32'(full),     32'(n == DEPTH));
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " rd_data"},  32'(rd_data),  (n > 0) ? 32'(mq[0].data) : 32'd0);
    check({tag, " rd_ts"},    32'(rd_ts),    (n > 0) ? 32'(mq[0].ts)   : 32'd0);
  endtask

  typedef struct packed {
    logic        rst;
    logic [7:0]  din;
    logic        rd;
    logic        clr;
    logic [2:0]  cnt;
    logic [7:0]  rdd;
    logic [15:0] rts;
    logic        emp;
    logic        ful;
    logic        ovf;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    rst = 1'b1; data_in = 8'h5A; rd_en = 1'b0; clr_ovf = 1'b0;

    //            rst din    rd clr cnt rdd    rts    emp ful ovf
    vecs[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 16'd3,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 16'd3,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 8'hA5, 16'd3,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h01, 1'b0, 1'b0, 3'd1, 8'h01, 16'd7,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h02, 1'b0, 1'b0, 3'd2, 8'h01, 16'd7,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h03, 1'b0, 1'b0, 3'd3, 8'h01, 16'd7,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h04, 1'b0, 1'b0, 3'd4, 8'h01, 16'd7,  1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h05, 1'b0, 1'b0, 3'd4, 8'h01, 16'd7,  1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h05, 1'b1, 1'b0, 3'd3, 8'h02, 16'd8,  1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'h05, 1'b1, 1'b0, 3'd2, 8'h03, 16'd9,  1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 8'h05, 1'b1, 1'b0, 3'd1, 8'h04, 16'd10, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h05, 1'b1, 1'b0, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 8'h05, 1'b0, 1'b1, 3'd0, 8'h00, 16'd0,  1'b1, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rst, vecs[i].din, vecs[i].rd, vecs[i].clr);
      check($sformatf("v%0d count", i),    32'(count),    32'(vecs[i].cnt));
      check($sformatf("v%0d rd_data", i),  32'(rd_data),  32'(vecs[i].rdd));
      check($sformatf("v%0d rd_ts", i),    32'(rd_ts),    32'(vecs[i].rts));
      check($sformatf("v%0d empty", i),    32'(empty),    32'(vecs[i].emp));
      check($sformatf("v%0d full", i),     32'(full),     32'(vecs[i].ful));
      check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
    end

    // Push and pop in the same cycle while full.
    apply(1'b0, 8'h11, 1'b0, 1'b0);
    apply(1'b0, 8'h12, 1'b0, 1'b0);
    apply(1'b0, 8'h13, 1'b0, 1'b0);
    apply(1'b0, 8'h14, 1'b0, 1'b0);
    check("fill count", 32'(count), 32'd4);
    apply(1'b0, 8'h15, 1'b1, 1'b0);
    check("pp_full count", 32'(count), 32'd4);
    check("pp_full overflow", 32'(overflow), 32'd0);
    check("pp_full head", 32'(rd_data), 32'h12);
    compare_model("pp_full");
    for (int i = 0; i < 3; i++) apply(1'b0, 8'h15, 1'b1, 1'b0);
    check("pp_full last", 32'(rd_data), 32'h15);
    compare_model("pp_drain");

    // Empty handling and overflow clear/set priority.
    apply(1'b0, 8'h15, 1'b1, 1'b0);
    apply(1'b0, 8'h15, 1'b1, 1'b0);
    check("rd_empty count", 32'(count), 32'd0);
    check("rd_empty empty", 32'(empty), 32'd1);
    check("rd_empty overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) apply(1'b0, 8'h21 + 8'(i), 1'b0, 1'b0);
    check("ovf set", 32'(overflow), 32'd1);
    apply(1'b0, 8'h25, 1'b0, 1'b1);
    check("ovf clr", 32'(overflow), 32'd0);
    apply(1'b0, 8'h26, 1'b0, 1'b1);
    check("ovf set_wins", 32'(overflow), 32'd1);
    check("ovf set_wins count", 32'(count), 32'd4);
    compare_model("ovf");

    // Reset mid-operation with three stored entries.
    apply(1'b0, 8'h26, 1'b1, 1'b0);
    check("mid count3", 32'(count), 32'd3);
    apply(1'b1, 8'h26, 1'b0, 1'b0);
    check("mid_rst count", 32'(count), 32'd0);
    check("mid_rst empty", 32'(empty), 32'd1);
    check("mid_rst overflow", 32'(overflow), 32'd0);
    apply(1'b0, 8'h77, 1'b0, 1'b0);
    check("mid baseline count", 32'(count), 32'd0);
    apply(1'b0, 8'h88, 1'b0, 1'b0);
    check("mid push count", 32'(count), 32'd1);
    check("mid push rd_data", 32'(rd_data), 32'h88);
    check("mid push rd_ts", 32'(rd_ts), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 99) < 2),
            8'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 10));
      compare_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
